// File: rtl/secure_stream_pkg.sv
// Shared types and sizing helpers for the secure stream serializer.
package secure_stream_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 512;
    localparam int DEF_BUS_W  = 16;

    function automatic int word_count(input int data_w, input int bus_w);
        return (data_w + bus_w - 1) / bus_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: the search starts at ptr and wraps around.
module rr_arbiter #(
    parameter int NUM_CH = 3,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] gnt_dbl;
    logic [NUM_CH-1:0]   rot_req;
    logic [NUM_CH-1:0]   rot_gnt;

    // Rotate so ptr sits at bit 0, isolate the lowest request, rotate back.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        rot_req = req_dbl[NUM_CH-1:0];
        rot_gnt = rot_req & (~rot_req + NUM_CH'(1));
        gnt_dbl = {rot_gnt, rot_gnt} << ptr;
        grant   = gnt_dbl[2*NUM_CH-1:NUM_CH];
    end

endmodule

// File: rtl/secure_stream_serializer.sv
// Buffers per-channel result payloads and streams them LSB-first over a
// shared valid/ready bus, one payload at a time, in round-robin order.
//
// state  | meaning
// S_IDLE | no payload in flight; grants the next pending channel
// S_SEND | shifting the granted payload out, one word per accepted transfer
module secure_stream_serializer
    import secure_stream_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BUS_W  = DEF_BUS_W
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CH-1:0]                           ch_load,
    input  logic [NUM_CH*DATA_W-1:0]                    ch_data,
    output logic [NUM_CH-1:0]                           ch_busy,
    output logic [NUM_CH-1:0]                           ch_done,
    output logic [NUM_CH-1:0]                           ch_overrun,
    input  logic                                        flush,
    output logic [BUS_W-1:0]                            out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic                                        out_last,
    output logic                                        out_valid,
    input  logic                                        out_ready
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WORDS = word_count(DATA_W, BUS_W);
    localparam int SH_W  = WORDS * BUS_W;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   busy_q, busy_d, done_q, ovr_q, gnt_q;
    logic [NUM_CH-1:0]   grant, capture;
    logic [CH_W-1:0]     ptr_q, ptr_next, ch_q, gidx;
    logic [CNT_W-1:0]    cnt_q;
    logic [SH_W-1:0]     shift_q, load_val;
    logic [DATA_W-1:0]   pay_q [NUM_CH];
    logic                take, advance, finish, at_last;

    // In IDLE nothing is in flight, so every busy channel is a pending request.
    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (CH_W)
    ) u_arb (
        .req   (busy_q),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        gidx     = '0;
        load_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                gidx                 = CH_W'(c);
                load_val[DATA_W-1:0] = pay_q[c];
            end
        end
    end

    assign ptr_next = (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + CH_W'(1);
    assign at_last  = (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|busy_q) begin
                        state_d = S_SEND;
                        take    = 1'b1;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (at_last) begin
                            finish  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        capture = ch_load & ~busy_q & {NUM_CH{~flush}};
        busy_d  = flush ? '0 : ((busy_q & ~(finish ? gnt_q : '0)) | capture);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            done_q <= '0;
            ovr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= finish ? gnt_q : '0;
            if (!flush) ovr_q <= ovr_q | (ch_load & busy_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else if (take) begin
            shift_q <= load_val;
            cnt_q   <= '0;
            ch_q    <= gidx;
            gnt_q   <= grant;
            ptr_q   <= ptr_next;
        end else if (advance) begin
            shift_q <= shift_q >> BUS_W;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Payload storage carries no reset; busy qualifies its contents.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (capture[c]) pay_q[c] <= ch_data[c*DATA_W +: DATA_W];
        end
    end

    assign out_valid  = (state_q == S_SEND);
    assign out_last   = (state_q == S_SEND) && at_last;
    assign out_data   = shift_q[BUS_W-1:0];
    assign out_ch     = ch_q;
    assign ch_busy    = busy_q;
    assign ch_done    = done_q;
    assign ch_overrun = ovr_q;

endmodule
